dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-ported
// data memory. Port 0 is the CPU datapath and port 1 is the loader. Each
// granted access occupies one BUSY cycle, and its ack is registered on the
// way back to IDLE.
module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] WORD_LIM = IDX_W'(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              rr_q, rr_d;          // 0: port 0 wins a tie, 1: port 1 wins
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic              in_range0, in_range1;
    logic              elig0, elig1;
    logic              sel_we, sel_in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign in_range0 = addr0[ADDR_W-1:2] < WORD_LIM;
    assign in_range1 = addr1[ADDR_W-1:2] < WORD_LIM;

    // A port that is seeing its own ack is still dropping req; skip it.
    assign elig0 = req0 & ~ack0_q;
    assign elig1 = req1 & ~ack1_q;

    // Memory-side mux: steer the granted port onto the memory bus.
    always_comb begin
        sel_we       = 1'b0;
        sel_in_range = 1'b0;
        sel_addr     = '0;
        sel_wdata    = '0;
        case (state_q)
            BUSY0: begin
                sel_we       = we0;
                sel_in_range = in_range0;
                sel_addr     = addr0;
                sel_wdata    = wdata0;
            end
            BUSY1: begin
                sel_we       = we1;
                sel_in_range = in_range1;
                sel_addr     = addr1;
                sel_wdata    = wdata1;
            end
            default: ;
        endcase
    end

    // Derived from the async-reset state, so reset drops mem_we at once.
    assign busy      = (state_q == BUSY0) || (state_q == BUSY1);
    assign mem_we    = sel_we & sel_in_range;
    assign mem_addr  = sel_addr;
    assign mem_wdata = sel_wdata;

    // Next-state: arbitrate in IDLE, complete and register response in BUSY.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = err0_q;
        err1_d   = err1_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (elig0 && (!elig1 || !rr_q)) begin
                    state_d = BUSY0;
                    rr_d    = 1'b1;
                end else if (elig1) begin
                    state_d = BUSY1;
                    rr_d    = 1'b0;
                end
            end
            BUSY0: begin
                state_d  = IDLE;
                ack0_d   = 1'b1;
                err0_d   = ~in_range0;
                rdata0_d = (we0 || !in_range0) ? '0 : mem_rdata;
            end
            BUSY1: begin
                state_d  = IDLE;
                ack1_d   = 1'b1;
                err1_d   = ~in_range1;
                rdata1_d = (we1 || !in_range1) ? '0 : mem_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign err0   = err0_q;
    assign err1   = err1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: attached memory, transaction-level reference model,
// per-cycle compare process, directed scenarios and a randomized phase.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rq[2];
    logic        wq[2];
    logic [31:0] aq[2];
    logic [31:0] dq[2];
    logic        ak[2];
    logic        er[2];
    logic [31:0] rd[2];
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(64)) dut (
        .clk(clk), .reset(reset),
        .req0(rq[0]), .req1(rq[1]), .we0(wq[0]), .we1(wq[1]),
        .addr0(aq[0]), .addr1(aq[1]), .wdata0(dq[0]), .wdata1(dq[1]),
        .ack0(ak[0]), .ack1(ak[1]), .err0(er[0]), .err1(er[1]),
        .rdata0(rd[0]), .rdata1(rd[1]),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic bit inr(input logic [31:0] a);
        return a[31:2] < 30'd64;
    endfunction

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Memory attached to the DUT
    logic [31:0] mem[64];
    always @(posedge clk) if (mem_we && inr(mem_addr)) mem[mem_addr[7:2]] <= mem_wdata;
    assign mem_rdata = inr(mem_addr) ? mem[mem_addr[7:2]] : 32'h0;

    // Reference model: which port is being served, tie-break pointer, last responses
    int          m_cur = -1;
    bit          m_rr = 0;
    bit          m_ack[2] = '{0, 0};
    bit          m_err[2] = '{0, 0};
    logic [31:0] m_rdata[2] = '{32'h0, 32'h0};
    logic [31:0] ref_mem[64];
    int          mp, mg;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cur = -1; m_rr = 0;
            m_ack = '{0, 0}; m_err = '{0, 0}; m_rdata = '{32'h0, 32'h0};
        end else if (m_cur >= 0) begin
            mp = m_cur;
            m_ack[mp] = 1; m_ack[1-mp] = 0;
            m_err[mp] = !inr(aq[mp]);
            m_rdata[mp] = (wq[mp] || !inr(aq[mp])) ? 32'h0 : ref_mem[aq[mp][7:2]];
            if (wq[mp] && inr(aq[mp])) ref_mem[aq[mp][7:2]] = dq[mp];
            m_cur = -1;
        end else begin
            mg = -1;
            if (rq[0] && !m_ack[0] && rq[1] && !m_ack[1]) mg = m_rr ? 1 : 0;
            else if (rq[0] && !m_ack[0]) mg = 0;
            else if (rq[1] && !m_ack[1]) mg = 1;
            m_ack = '{0, 0};
            if (mg >= 0) begin
                m_cur = mg;
                m_rr = (mg == 0);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_cur >= 0));
            chk("mem_we", 64'(mem_we), 64'((m_cur >= 0) && wq[m_cur == 1] && inr(aq[m_cur == 1])));
            chk("mem_addr", 64'(mem_addr), 64'((m_cur >= 0) ? aq[m_cur == 1] : 32'h0));
            chk("mem_wdata", 64'(mem_wdata), 64'((m_cur >= 0) ? dq[m_cur == 1] : 32'h0));
            chk("ack0", 64'(ak[0]), 64'(m_ack[0]));
            chk("ack1", 64'(ak[1]), 64'(m_ack[1]));
            chk("err0", 64'(er[0]), 64'(m_err[0]));
            chk("err1", 64'(er[1]), 64'(m_err[1]));
            chk("rdata0", 64'(rd[0]), 64'(m_rdata[0]));
            chk("rdata1", 64'(rd[1]), 64'(m_rdata[1]));
            chk("ack_overlap", 64'(ak[0] && ak[1]), 64'd0);
        end
    end

    task automatic do_reset();
        @(negedge clk); #1;
        reset = 0;
        rq = '{0, 0};
        @(negedge clk); #1;
        reset = 1;
    endtask

    // Single access on port p; returns response and cycles from request to ack
    task automatic acc(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic e, output int lat);
        bit got;
        @(negedge clk); #1;
        rq[p] = 1; wq[p] = w; aq[p] = a; dq[p] = d;
        lat = 0; got = 0;
        while (!got && lat < 12) begin
            @(negedge clk); #1;
            lat++;
            if (ak[p]) got = 1;
        end
        if (!got) chk("ack_timeout", 64'd0, 64'd1);
        r = rd[p]; e = er[p];
        rq[p] = 0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [29:0] w;
        case ($urandom_range(0, 7))
            0:       w = 30'($urandom_range(64, 80));
            1:       w = 30'($urandom);
            default: w = 30'($urandom_range(0, 63));
        endcase
        return {w, 2'($urandom_range(0, 3))};
    endfunction

    initial begin
        logic [31:0] r;
        logic        e;
        int          lat;
        bit          pend[2];

        rq = '{0, 0}; wq = '{0, 0}; aq = '{32'h0, 32'h0}; dq = '{32'h0, 32'h0};
        for (int i = 0; i < 64; i++) begin
            mem[i] = init_val(i);
            ref_mem[i] = init_val(i);
        end
        repeat (2) @(negedge clk);
        chk_en = 1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_ack", 64'({ak[0], ak[1], er[0], er[1]}), 64'd0);
        chk("rst_rdata", 64'({rd[0], rd[1]}), 64'd0);
        @(negedge clk); #1;
        reset = 1;

        // Idle bus
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("idle_quiet", 64'({busy, mem_we, ak[0], ak[1], er[0], er[1]}), 64'd0);
        end

        // Write then read back on port 0
        acc(0, 1, 32'h8, 32'hDEADBEEF, r, e, lat);
        chk("wr_latency", 64'(lat), 64'd2);
        acc(0, 0, 32'h8, 32'h0, r, e, lat);
        chk("rd_data", 64'(r), 64'hDEADBEEF);
        chk("rd_err", 64'(e), 64'd0);

        // Out-of-range write on port 1, word 63 untouched
        acc(1, 1, 32'h100, 32'hFF, r, e, lat);
        chk("oor_err", 64'(e), 64'd1);
        chk("oor_rdata", 64'(r), 64'd0);
        acc(0, 0, 32'hFC, 32'h0, r, e, lat);
        chk("w63_data", 64'(r), 64'(init_val(63)));

        // Req held through the ack cycle is not re-granted
        @(negedge clk); #1;
        rq[0] = 1; wq[0] = 0; aq[0] = 32'h8;
        lat = 0;
        while (!ak[0] && lat < 12) begin @(negedge clk); #1; lat++; end
        chk("hold_ack_seen", 64'(ak[0]), 64'd1);
        @(negedge clk); #1;
        chk("hold_no_regrant", 64'(busy), 64'd0);
        rq[0] = 0;
        @(negedge clk); #1;
        chk("hold_still_idle", 64'(busy), 64'd0);

        // Both ports requesting continuously from reset
        do_reset();
        rq = '{1, 1}; wq = '{0, 0}; aq = '{32'h0, 32'h4};
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1;
            chk("rr_ack0", 64'(ak[0]), 64'(i % 4 == 1));
            chk("rr_ack1", 64'(ak[1]), 64'(i % 4 == 3));
        end
        rq = '{0, 0};
        repeat (3) @(negedge clk);

        // Reset during a write on port 1
        #1;
        rq[1] = 1; wq[1] = 1; aq[1] = 32'h4; dq[1] = 32'h55;
        @(negedge clk); #1;
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_mem_we", 64'(mem_we), 64'd1);
        #1 reset = 0;
        #1;
        chk("mid_we_drop", 64'(mem_we), 64'd0);
        chk("mid_busy_drop", 64'(busy), 64'd0);
        rq[1] = 0;
        @(negedge clk); #1;
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("mid_no_ack", 64'(ak[1]), 64'd0);
        end
        acc(1, 0, 32'h4, 32'h0, r, e, lat);
        chk("mid_old_val", 64'(r), 64'(init_val(1)));

        // Randomized traffic from both ports
        pend = '{0, 0};
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && ak[p]) pend[p] = 0;
                if (!pend[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rq[p] = 1; wq[p] = 1'($urandom_range(0, 1));
                        aq[p] = rand_addr(); dq[p] = $urandom; pend[p] = 1;
                    end else begin
                        rq[p] = 0;
                    end
                end
            end
            if (c == 1500) begin
                reset = 0; pend = '{0, 0}; rq = '{0, 0};
                @(negedge clk); #1;
                reset = 1;
            end
        end
        rq = '{0, 0};
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
